lmc_exec: RTL
=============

LMC_EXEC -- requirements
Module: lmc_exec

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: width of program and data addresses.
REQ-002 Parameter DATA_WIDTH, default 8: width of the instruction, accumulator and data words.
REQ-003 timer555  input  1: sole clock; all state updates on its rising edge.
REQ-004 reset_count  input  1: reset, synchronous, active-high.
REQ-005 instr  input  DATA_WIDTH: instruction word from the program RAM at the current PC.
REQ-006 mem_raddr  output  ADDR_WIDTH: operand read address, equal to IR[3:0].
REQ-007 mem_rdata  input  DATA_WIDTH: combinational read data at mem_raddr.
REQ-008 mem_we  output  1: one-cycle write strobe; mem_waddr equals IR[3:0] and mem_wdata equals acc.
REQ-009 pc_step  output  1: one-cycle pulse that advances the upstream counter by 1.
REQ-010 pc_load  output  1: one-cycle pulse that loads pc_target into the upstream counter.
REQ-011 pc_target  output  ADDR_WIDTH: branch destination.
REQ-012 in_data  input  DATA_WIDTH and in_valid  input  1: input port; in_ack  output  1 pulses when a word is consumed.
REQ-013 out_data  output  DATA_WIDTH, out_valid  output  1, out_ready  input  1: output port handshake.
REQ-014 acc  output  DATA_WIDTH, neg  output  1, halted  output  1: architectural status.

Function
REQ-015 Opcode is IR[7:4] and address is IR[3:0]: 0 HLT, 1 ADD, 2 SUB, 3 STA, 4 LDA, 5 INP, 6 OUT, 8 BRA, 9 BRZ, A BRP; all other opcodes are NOP.
REQ-016 The FSM states are FETCH, EXEC, WAIT_IN, WAIT_OUT and HALT.
REQ-017 FETCH shall latch instr into IR and go to EXEC, so every instruction takes at least 2 cycles.
REQ-018 In EXEC, ADD sets acc to acc+mem_rdata and clears neg.
REQ-019 In EXEC, SUB sets acc to acc-mem_rdata and sets neg to 1 when the subtraction borrows, else 0.
REQ-020 In EXEC, LDA sets acc to mem_rdata and clears neg.
REQ-021 In EXEC, STA asserts mem_we for exactly 1 cycle.
REQ-022 In EXEC, BRA asserts pc_load with pc_target set to IR[3:0].
REQ-023 In EXEC, BRZ asserts pc_load if acc==0 and neg==0, else pc_step.
REQ-024 In EXEC, BRP asserts pc_load if neg==0, else pc_step.
REQ-025 Every non-branch, non-halt instruction asserts pc_step on its completing cycle; pc_step and pc_load shall never both be high.
REQ-026 INP goes to WAIT_IN and stays there until in_valid==1; in that cycle acc is set to in_data, neg is cleared, in_ack and pc_step pulse, and the next state is FETCH.
REQ-027 OUT loads out_data with acc, raises out_valid and goes to WAIT_OUT.
REQ-028 In WAIT_OUT, out_valid stays high until a cycle with out_ready==1; in that cycle out_valid drops, pc_step pulses and the next state is FETCH.
REQ-029 out_data shall be stable while out_valid is high.
REQ-030 HLT enters HALT and sets halted to 1; HALT is left only by reset, and no strobes are asserted while in HALT.
REQ-031 Arithmetic is DATA_WIDTH wide; with LMC_EXEC_SAT_EN absent, results wrap modulo 2^DATA_WIDTH.
REQ-032 After pc_step or pc_load the FSM returns to FETCH, and instr is sampled one cycle later, after the upstream counter has updated.

Reset
REQ-033 When reset_count is sampled high, the FSM is in FETCH and acc=0, neg=0, halted=0, IR=0, out_data=0, and every strobe and valid output is 0.
REQ-034 Reset dominates every state, including WAIT_IN, WAIT_OUT and HALT, and aborts any pending handshake without issuing in_ack or pc_step.

Configuration
REQ-035 With macro LMC_EXEC_SAT_EN defined, ADD clamps at 2^DATA_WIDTH-1 and SUB clamps at 0 while still setting neg on borrow.
REQ-036 Without LMC_EXEC_SAT_EN, ADD and SUB wrap as specified in REQ-031.

Structure
REQ-037 A shared package lmc_pkg holds the opcode constants, the FSM state enumeration and the ADDR_WIDTH/DATA_WIDTH defaults.
REQ-038 One sub-module, lmc_alu, is combinational and computes the ADD/SUB result and the borrow, including the saturation option.

Verification
REQ-039 Reset, then program LDA 5 (mem[5]=0x07), ADD 6 (mem[6]=0x03), OUT, HLT with out_ready=1 -> out_data=0x0A with one out_valid pulse, then halted=1.
REQ-040 acc=0x02, SUB of 0x05 -> acc=0xFD and neg=1 without the macro; acc=0x00 and neg=1 with it.
REQ-041 BRZ 0x9 with acc=0 -> pc_load with pc_target=0x9; the same with acc=1 -> pc_step only.
REQ-042 INP with in_valid held low for 5 cycles, then in_data=0x42 -> no strobes during the wait, then acc=0x42 and a single in_ack with pc_step.
REQ-043 OUT with out_ready low for 3 cycles -> out_data held stable and out_valid high throughout, then exactly one pc_step.
REQ-044 reset_count asserted in WAIT_OUT and again in HALT -> next cycle in FETCH with all outputs at reset values and no pc_step.

Source files
------------

// File: rtl/lmc_pkg.sv
// -----------------------------------------------------------------------------
// lmc_pkg
// Shared definitions for the little-man-computer execution core: default
// address/data widths, the 4-bit opcode constants, the control FSM state
// enumeration and a small helper that splits an instruction word.
// -----------------------------------------------------------------------------
package lmc_pkg;

    localparam int LMC_ADDR_WIDTH = 4;
    localparam int LMC_DATA_WIDTH = 8;

    // Opcodes live in IR[7:4]; anything not listed here executes as a NOP.
    localparam logic [3:0] OP_HLT = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_LDA = 4'h4;
    localparam logic [3:0] OP_INP = 4'h5;
    localparam logic [3:0] OP_OUT = 4'h6;
    localparam logic [3:0] OP_BRA = 4'h8;
    localparam logic [3:0] OP_BRZ = 4'h9;
    localparam logic [3:0] OP_BRP = 4'hA;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_EXEC     = 3'd1,
        ST_WAIT_IN  = 3'd2,
        ST_WAIT_OUT = 3'd3,
        ST_HALT     = 3'd4
    } lmc_state_e;

    // Opcode field of an instruction word.
    function automatic logic [3:0] opcode_of(input logic [7:0] ir);
        return ir[7:4];
    endfunction

    // Address/operand field of an instruction word.
    function automatic logic [3:0] operand_of(input logic [7:0] ir);
        return ir[3:0];
    endfunction

endpackage

// File: rtl/lmc_alu.sv
// -----------------------------------------------------------------------------
// lmc_alu
// Purely combinational adder/subtractor for the accumulator path.
//
// Ports
//   a       in  DATA_WIDTH  accumulator value
//   b       in  DATA_WIDTH  memory operand
//   op_sub  in  1           1 = a-b, 0 = a+b
//   result  out DATA_WIDTH  sum or difference
//   borrow  out 1           set when a-b borrows (b > a, unsigned); 0 for add
//
// Build option: macro LMC_EXEC_SAT_EN selects saturating arithmetic (add
// clamps at all-ones, subtract clamps at zero). Without it results wrap.
// The borrow flag is reported identically in both builds.
// -----------------------------------------------------------------------------
module lmc_alu
    import lmc_pkg::*;
#(
    parameter int DATA_WIDTH = LMC_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  op_sub,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  borrow
);

`ifdef LMC_EXEC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // One extra bit on each path exposes carry-out and borrow-out.
    logic [DATA_WIDTH:0] sum_ext;
    logic [DATA_WIDTH:0] diff_ext;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = sum_ext[DATA_WIDTH-1:0];
        borrow = 1'b0;
        if (op_sub) begin
            borrow = diff_ext[DATA_WIDTH];
            result = diff_ext[DATA_WIDTH-1:0];
            if (SAT_EN && diff_ext[DATA_WIDTH]) begin
                result = '0;
            end
        end else begin
            if (SAT_EN && sum_ext[DATA_WIDTH]) begin
                result = '1;
            end
        end
    end

endmodule

// File: rtl/lmc_exec.sv
// -----------------------------------------------------------------------------
// lmc_exec
// Execution core of a little-man-computer. The program counter and the
// program/data RAMs sit outside; this block fetches the word presented on
// instr, executes it and tells the upstream counter to step or load.
//
// Ports
//   timer555     in   sole clock, rising edge
//   reset_count  in   synchronous active-high reset
//   instr        in   instruction word at the current PC
//   mem_raddr    out  operand read address (IR[3:0])
//   mem_rdata    in   combinational data at mem_raddr
//   mem_we       out  one-cycle write strobe (STA)
//   mem_waddr    out  write address (IR[3:0])
//   mem_wdata    out  write data (accumulator)
//   pc_step      out  one-cycle "advance PC by one" pulse
//   pc_load      out  one-cycle "load pc_target" pulse
//   pc_target    out  branch destination (IR[3:0])
//   in_data/in_valid/in_ack     input port; in_ack pulses on consumption
//   out_data/out_valid/out_ready output port, valid/ready handshake
//   acc, neg, halted            architectural status
//
// Build option: LMC_EXEC_SAT_EN makes ADD/SUB saturate (see lmc_alu).
//
// Every instruction spends one FETCH cycle (IR <= instr) and at least one
// EXEC cycle. The step/load pulse is issued on the completing cycle and the
// FSM then returns to FETCH, so the next instr is sampled after the
// upstream counter has taken the pulse. All strobes are combinational from
// the current state and are forced low while reset_count is high, which
// aborts any pending handshake without acknowledging it.
// -----------------------------------------------------------------------------
module lmc_exec
    import lmc_pkg::*;
#(
    parameter int ADDR_WIDTH = LMC_ADDR_WIDTH,
    parameter int DATA_WIDTH = LMC_DATA_WIDTH
) (
    input  logic                  timer555,
    input  logic                  reset_count,
    input  logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  pc_step,
    output logic                  pc_load,
    output logic [ADDR_WIDTH-1:0] pc_target,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ack,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] acc,
    output logic                  neg,
    output logic                  halted
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    lmc_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  neg_q, neg_d;
    logic                  halted_q, halted_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;

    // Raw strobes from the FSM, before reset gating.
    logic step_raw;
    logic load_raw;
    logic we_raw;
    logic ack_raw;

    // Instruction fields. The ISA fixes the opcode in IR[7:4] and the
    // address in IR[3:0] regardless of the configured widths.
    logic [3:0] opcode;
    logic [3:0] operand;

    assign opcode  = opcode_of(ir_q[7:0]);
    assign operand = operand_of(ir_q[7:0]);

    // -------------------------------------------------------------------------
    // Arithmetic
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_borrow;

    lmc_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .a      (acc_q),
        .b      (mem_rdata),
        .op_sub (opcode == OP_SUB),
        .result (alu_result),
        .borrow (alu_borrow)
    );

    // -------------------------------------------------------------------------
    // Next-state and strobe logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        acc_d       = acc_q;
        neg_d       = neg_q;
        halted_d    = halted_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        step_raw    = 1'b0;
        load_raw    = 1'b0;
        we_raw      = 1'b0;
        ack_raw     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                ir_d    = instr;
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                // Default: single-cycle instruction that steps the PC.
                state_d = ST_FETCH;
                case (opcode)
                    OP_HLT: begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end
                    OP_ADD, OP_SUB: begin
                        acc_d    = alu_result;
                        neg_d    = alu_borrow;
                        step_raw = 1'b1;
                    end
                    OP_STA: begin
                        we_raw   = 1'b1;
                        step_raw = 1'b1;
                    end
                    OP_LDA: begin
                        acc_d    = mem_rdata;
                        neg_d    = 1'b0;
                        step_raw = 1'b1;
                    end
                    OP_INP: begin
                        state_d = ST_WAIT_IN;
                    end
                    OP_OUT: begin
                        // out_data is captured here and not touched again
                        // until the handshake completes, so it stays stable.
                        out_data_d  = acc_q;
                        out_valid_d = 1'b1;
                        state_d     = ST_WAIT_OUT;
                    end
                    OP_BRA: begin
                        load_raw = 1'b1;
                    end
                    OP_BRZ: begin
                        if ((acc_q == '0) && !neg_q) begin
                            load_raw = 1'b1;
                        end else begin
                            step_raw = 1'b1;
                        end
                    end
                    OP_BRP: begin
                        if (!neg_q) begin
                            load_raw = 1'b1;
                        end else begin
                            step_raw = 1'b1;
                        end
                    end
                    default: begin
                        step_raw = 1'b1;
                    end
                endcase
            end

            ST_WAIT_IN: begin
                if (in_valid) begin
                    acc_d    = in_data;
                    neg_d    = 1'b0;
                    ack_raw  = 1'b1;
                    step_raw = 1'b1;
                    state_d  = ST_FETCH;
                end
            end

            ST_WAIT_OUT: begin
                // out_valid is high for this whole state; the word transfers
                // in the cycle out_ready is seen, then valid drops.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    step_raw    = 1'b1;
                    state_d     = ST_FETCH;
                end
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge timer555) begin
        if (reset_count) begin
            state_q     <= ST_FETCH;
            ir_q        <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            halted_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            acc_q       <= acc_d;
            neg_q       <= neg_d;
            halted_q    <= halted_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign pc_step   = step_raw & ~reset_count;
    assign pc_load   = load_raw & ~reset_count;
    assign mem_we    = we_raw   & ~reset_count;
    assign in_ack    = ack_raw  & ~reset_count;

    assign mem_raddr = ADDR_WIDTH'(operand);
    assign mem_waddr = ADDR_WIDTH'(operand);
    assign mem_wdata = acc_q;
    assign pc_target = ADDR_WIDTH'(operand);

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign acc       = acc_q;
    assign neg       = neg_q;
    assign halted    = halted_q;

endmodule
